// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: drives the ROM address every cycle and queues
// fetched instructions with their next-PC in a DEPTH-entry circular buffer.
module fetch_prefetch_queue #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_STEP = 4
) (
  input  logic                             clk,
  input  logic                             R,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [INSTR_W-1:0]               rom_instr,
  input  logic                             branch_taken,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             deq,
  output logic                             head_valid,
  output logic [INSTR_W-1:0]               head_instr,
  output logic [ADDR_W-1:0]                head_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [ADDR_W-1:0]                fetch_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] r_instr_q [DEPTH];
  logic [ADDR_W-1:0]  r_npc_q   [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_fetch_pc;

  logic               w_head_valid;
  logic               w_do_deq;
  logic               w_can_enq;
  logic [ADDR_W-1:0]  w_next_pc;

  assign w_head_valid = (r_count != '0);
  assign w_do_deq     = deq & w_head_valid;
  // A full queue still takes a fetch when the head leaves in the same cycle.
  assign w_can_enq    = (r_count < CNT_W'(DEPTH)) | w_do_deq;
  assign w_next_pc    = r_fetch_pc + ADDR_W'(PC_STEP);

  // Control state: reset beats branch redirect beats normal fetch/drain.
  always_ff @(posedge clk) begin
    if (R) begin
      r_fetch_pc <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (branch_taken) begin
      r_fetch_pc <= branch_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_can_enq) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_fetch_pc <= w_next_pc;
      end
      if (w_do_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_can_enq) - CNT_W'(w_do_deq);
    end
  end

  // Payload storage needs no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (!R && !branch_taken && w_can_enq) begin
      r_instr_q[r_wr_ptr] <= rom_instr;
      r_npc_q[r_wr_ptr]   <= w_next_pc;
    end
  end

  assign rom_addr     = r_fetch_pc;
  assign fetch_pc     = r_fetch_pc;
  assign count        = r_count;
  assign head_valid   = w_head_valid;
  assign head_instr   = w_head_valid ? r_instr_q[r_rd_ptr] : '0;
  assign head_next_pc = w_head_valid ? r_npc_q[r_rd_ptr]   : '0;

endmodule
